// File: rtl/i2c_regbank_arbiter_if.sv
// Bus bundle between the register bank, the I2C slave register port and
// the local host port.
interface i2c_regbank_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 16
);
   // I2C slave register port
   logic                  i2c_write_en;
   logic [ADDR_WIDTH-1:0] i2c_reg_addr;
   logic [DATA_WIDTH-1:0] i2c_wdata;
   logic [DATA_WIDTH-1:0] i2c_rdata;
   logic                  i2c_busy;
   logic                  i2c_done;
   // Host request/ack port
   logic                  host_req;
   logic                  host_we;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [DATA_WIDTH-1:0] host_wdata;
   logic [DATA_WIDTH-1:0] host_rdata;
   logic                  host_ack;
   logic                  host_err;
   // Interrupt
   logic                  irq;
   logic [ADDR_WIDTH-1:0] irq_addr;
   logic                  irq_clr;

   // Register bank side
   modport slave (
      input  i2c_write_en, i2c_reg_addr, i2c_wdata, i2c_busy, i2c_done,
      input  host_req, host_we, host_addr, host_wdata, irq_clr,
      output i2c_rdata, host_rdata, host_ack, host_err, irq, irq_addr
   );

   // Requester side (I2C slave plus host)
   modport master (
      output i2c_write_en, i2c_reg_addr, i2c_wdata, i2c_busy, i2c_done,
      output host_req, host_we, host_addr, host_wdata, irq_clr,
      input  i2c_rdata, host_rdata, host_ack, host_err, irq, irq_addr
   );
endinterface

// File: rtl/i2c_regbank_arbiter.sv
// Register bank shared by an I2C slave (combinational read, priority write)
// and a local host (req/ack handshake, deferred on collision or I2C lock).
// A sticky irq flags that an I2C transaction wrote to the bank.
module i2c_regbank_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned NUM_REGS     = 16,
   parameter bit          LOCK_ON_BUSY = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   i2c_regbank_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACK} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic                  cap_we_q;
   logic [ADDR_WIDTH-1:0] cap_addr_q;
   logic [DATA_WIDTH-1:0] cap_wdata_q;
   logic [DATA_WIDTH-1:0] host_rdata_q;
   logic                  host_ack_q;
   logic                  host_err_q;
   logic                  irq_q;
   logic [ADDR_WIDTH-1:0] irq_addr_q;
   logic                  wr_seen_q;

   logic                  capture;
   logic                  exec_done;
   logic                  stall;
   logic                  i2c_ok;
   logic                  cap_ok;
   logic                  i2c_wr_ok;
   logic [IDX_W-1:0]      i2c_idx;
   logic [IDX_W-1:0]      cap_idx;

   assign i2c_ok    = {1'b0, bus.i2c_reg_addr} < (ADDR_WIDTH+1)'(NUM_REGS);
   assign cap_ok    = {1'b0, cap_addr_q} < (ADDR_WIDTH+1)'(NUM_REGS);
   assign i2c_idx   = bus.i2c_reg_addr[IDX_W-1:0];
   assign cap_idx   = cap_addr_q[IDX_W-1:0];
   assign i2c_wr_ok = bus.i2c_write_en && i2c_ok;
   assign stall     = (LOCK_ON_BUSY && bus.i2c_busy) || bus.i2c_write_en;

   // Combinational I2C read path, zero for unimplemented addresses
   always_comb begin
      bus.i2c_rdata = '0;
      if (i2c_ok) begin
         bus.i2c_rdata = regs_q[i2c_idx];
      end
   end

   // Host FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Host FSM next state: accept, wait out stalls, then hold until req drops
   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      exec_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.host_req) begin
               capture = 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!stall) begin
               exec_done = 1'b1;
               state_d   = S_ACK;
            end
         end
         S_ACK: begin
            if (!bus.host_req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request capture and registered host response
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_we_q     <= 1'b0;
         cap_addr_q   <= '0;
         cap_wdata_q  <= '0;
         host_rdata_q <= '0;
         host_ack_q   <= 1'b0;
         host_err_q   <= 1'b0;
      end else begin
         if (capture) begin
            cap_we_q    <= bus.host_we;
            cap_addr_q  <= bus.host_addr;
            cap_wdata_q <= bus.host_wdata;
         end
         host_ack_q <= exec_done;
         host_err_q <= exec_done && !cap_ok;
         if (exec_done) begin
            if (!cap_ok)        host_rdata_q <= '0;
            else if (!cap_we_q) host_rdata_q <= regs_q[cap_idx];
         end
      end
   end

   // Register file: a host write only completes in a cycle without an I2C write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q     <= '{default: '0};
         irq_addr_q <= '0;
      end else if (i2c_wr_ok) begin
         regs_q[i2c_idx] <= bus.i2c_wdata;
         irq_addr_q      <= bus.i2c_reg_addr;
      end else if (exec_done && cap_ok && cap_we_q) begin
         regs_q[cap_idx] <= cap_wdata_q;
      end
   end

   // Sticky irq; a write landing on the done edge stays pending for the next one
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_q     <= 1'b0;
         wr_seen_q <= 1'b0;
      end else begin
         if (bus.i2c_done && wr_seen_q) irq_q <= 1'b1;
         else if (bus.irq_clr)          irq_q <= 1'b0;
         if (i2c_wr_ok)                         wr_seen_q <= 1'b1;
         else if (bus.i2c_done && wr_seen_q)    wr_seen_q <= 1'b0;
      end
   end

   assign bus.host_rdata = host_rdata_q;
   assign bus.host_ack   = host_ack_q;
   assign bus.host_err   = host_err_q;
   assign bus.irq        = irq_q;
   assign bus.irq_addr   = irq_addr_q;

endmodule

// File: tb/tb_i2c_regbank_arbiter.sv
// Directed bench for i2c_regbank_arbiter: handshake latency, irq, collision,
// I2C lock, unimplemented addresses and reset during an access.
module tb_i2c_regbank_arbiter;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   i2c_regbank_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

   i2c_regbank_arbiter #(
      .ADDR_WIDTH  (8),
      .DATA_WIDTH  (16),
      .NUM_REGS    (16),
      .LOCK_ON_BUSY(1'b1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Host transaction: returns edges from req to ack (limit on timeout)
   task automatic host_xfer(input logic we, input logic [7:0] addr,
                            input logic [15:0] wdata, input int limit,
                            output int cyc, output logic [15:0] rdata,
                            output logic err);
      bus.host_we    = we;
      bus.host_addr  = addr;
      bus.host_wdata = wdata;
      bus.host_req   = 1'b1;
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!bus.host_ack && cyc < limit);
      rdata = bus.host_rdata;
      err   = bus.host_err;
      bus.host_req = 1'b0;
      tick();
   endtask

   task automatic i2c_write(input logic [7:0] addr, input logic [15:0] data);
      bus.i2c_reg_addr = addr;
      bus.i2c_wdata    = data;
      bus.i2c_write_en = 1'b1;
      tick();
      bus.i2c_write_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      tick();
      vectors++;
      if (bus.host_ack !== 1'b0 || bus.host_err !== 1'b0 || bus.host_rdata !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_host: ack=%b err=%b rdata=%h required 0 0 0000",
                  bus.host_ack, bus.host_err, bus.host_rdata);
      end
      vectors++;
      if (bus.irq !== 1'b0 || bus.irq_addr !== 8'h0) begin
         miscompares++;
         $display("FAIL reset_irq: irq=%b irq_addr=%h required 0 00", bus.irq, bus.irq_addr);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int cyc;
      logic [15:0] rd;
      logic err;
      host_xfer(1'b1, 8'd3, 16'hBEEF, 10, cyc, rd, err);
      vectors++;
      if (cyc !== 2 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL wr3_latency: cycles=%0d err=%b required 2 0", cyc, err);
      end
      host_xfer(1'b0, 8'd3, 16'h0000, 10, cyc, rd, err);
      vectors++;
      if (cyc !== 2 || rd !== 16'hBEEF || err !== 1'b0) begin
         miscompares++;
         $display("FAIL rd3: cycles=%0d rdata=%h err=%b required 2 beef 0", cyc, rd, err);
      end
      bus.i2c_reg_addr = 8'd3;
      #1;
      vectors++;
      if (bus.i2c_rdata !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL i2c_rd3: got %h required beef", bus.i2c_rdata);
      end
      // last implemented register
      host_xfer(1'b1, 8'd15, 16'hC0DE, 10, cyc, rd, err);
      bus.i2c_reg_addr = 8'd15;
      #1;
      vectors++;
      if (bus.i2c_rdata !== 16'hC0DE || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reg15: got %h err=%b required c0de 0", bus.i2c_rdata, err);
      end
   endtask

   task automatic test_irq();
      i2c_write(8'd5, 16'h1234);
      #1;
      vectors++;
      if (bus.i2c_rdata !== 16'h1234 || bus.irq !== 1'b0) begin
         miscompares++;
         $display("FAIL i2c_wr5: rdata=%h irq=%b required 1234 0", bus.i2c_rdata, bus.irq);
      end
      bus.i2c_done = 1'b1;
      tick();
      bus.i2c_done = 1'b0;
      vectors++;
      if (bus.irq !== 1'b1 || bus.irq_addr !== 8'd5) begin
         miscompares++;
         $display("FAIL irq_set: irq=%b irq_addr=%h required 1 05", bus.irq, bus.irq_addr);
      end
      bus.irq_clr = 1'b1;
      tick();
      bus.irq_clr = 1'b0;
      vectors++;
      if (bus.irq !== 1'b0) begin
         miscompares++;
         $display("FAIL irq_clr: irq=%b required 0", bus.irq);
      end
      bus.i2c_done = 1'b1;
      tick();
      bus.i2c_done = 1'b0;
      vectors++;
      if (bus.irq !== 1'b0) begin
         miscompares++;
         $display("FAIL irq_read_only: irq=%b required 0", bus.irq);
      end
      // set and clear on the same edge: set wins
      i2c_write(8'd6, 16'h0606);
      bus.i2c_done = 1'b1;
      bus.irq_clr  = 1'b1;
      tick();
      bus.i2c_done = 1'b0;
      bus.irq_clr  = 1'b0;
      vectors++;
      if (bus.irq !== 1'b1 || bus.irq_addr !== 8'd6) begin
         miscompares++;
         $display("FAIL irq_set_wins: irq=%b irq_addr=%h required 1 06", bus.irq, bus.irq_addr);
      end
      bus.irq_clr = 1'b1;
      tick();
      bus.irq_clr = 1'b0;
   endtask

   task automatic test_collision();
      bus.host_we    = 1'b1;
      bus.host_addr  = 8'd7;
      bus.host_wdata = 16'hAAAA;
      bus.host_req   = 1'b1;
      tick();
      // host request now in execute; I2C writes the same register
      bus.i2c_reg_addr = 8'd7;
      bus.i2c_wdata    = 16'h5555;
      bus.i2c_write_en = 1'b1;
      tick();
      bus.i2c_write_en = 1'b0;
      #1;
      vectors++;
      if (bus.host_ack !== 1'b0 || bus.i2c_rdata !== 16'h5555) begin
         miscompares++;
         $display("FAIL coll_stall: ack=%b rdata=%h required 0 5555", bus.host_ack, bus.i2c_rdata);
      end
      tick();
      vectors++;
      if (bus.host_ack !== 1'b1) begin
         miscompares++;
         $display("FAIL coll_ack: ack=%b required 1", bus.host_ack);
      end
      bus.host_req = 1'b0;
      tick();
      vectors++;
      if (bus.i2c_rdata !== 16'hAAAA || bus.host_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL coll_final: rdata=%h ack=%b required aaaa 0", bus.i2c_rdata, bus.host_ack);
      end
   endtask

   task automatic test_lock();
      int acks;
      acks = 0;
      bus.i2c_busy  = 1'b1;
      bus.host_we   = 1'b0;
      bus.host_addr = 8'd3;
      bus.host_req  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.host_ack) acks++;
      end
      vectors++;
      if (acks !== 0) begin
         miscompares++;
         $display("FAIL lock_hold: acks=%0d required 0", acks);
      end
      bus.i2c_busy = 1'b0;
      tick();
      vectors++;
      if (bus.host_ack !== 1'b1 || bus.host_rdata !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL lock_release: ack=%b rdata=%h required 1 beef", bus.host_ack, bus.host_rdata);
      end
      bus.host_req = 1'b0;
      tick();
   endtask

   task automatic test_unimpl();
      int cyc;
      logic [15:0] rd;
      logic err;
      host_xfer(1'b0, 8'd20, 16'h0000, 10, cyc, rd, err);
      vectors++;
      if (cyc !== 2 || err !== 1'b1 || rd !== 16'h0000) begin
         miscompares++;
         $display("FAIL rd20: cycles=%0d err=%b rdata=%h required 2 1 0000", cyc, err, rd);
      end
      i2c_write(8'd20, 16'hFFFF);
      #1;
      vectors++;
      if (bus.irq_addr !== 8'd7 || bus.i2c_rdata !== 16'h0000) begin
         miscompares++;
         $display("FAIL i2c_wr20: irq_addr=%h rdata=%h required 07 0000", bus.irq_addr, bus.i2c_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int acks;
      int cyc;
      logic [15:0] rd;
      logic err;
      acks = 0;
      bus.i2c_busy   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_addr  = 8'd2;
      bus.host_wdata = 16'h1111;
      bus.host_req   = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #2;
      bus.host_req = 1'b0;
      bus.i2c_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.host_ack) acks++;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.host_ack) acks++;
      end
      vectors++;
      if (acks !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_ack: acks=%0d required 0", acks);
      end
      for (int a = 2; a <= 7; a++) begin
         bus.i2c_reg_addr = 8'(a);
         #1;
         vectors++;
         if (bus.i2c_rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_reg%0d: got %h required 0000", a, bus.i2c_rdata);
         end
      end
      host_xfer(1'b1, 8'd9, 16'h9999, 10, cyc, rd, err);
      bus.i2c_reg_addr = 8'd9;
      #1;
      vectors++;
      if (cyc !== 2 || err !== 1'b0 || bus.i2c_rdata !== 16'h9999) begin
         miscompares++;
         $display("FAIL reset_mid_new: cycles=%0d err=%b rdata=%h required 2 0 9999",
                  cyc, err, bus.i2c_rdata);
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b1;
      bus.i2c_write_en = 1'b0;
      bus.i2c_reg_addr = '0;
      bus.i2c_wdata    = '0;
      bus.i2c_busy     = 1'b0;
      bus.i2c_done     = 1'b0;
      bus.host_req     = 1'b0;
      bus.host_we      = 1'b0;
      bus.host_addr    = '0;
      bus.host_wdata   = '0;
      bus.irq_clr      = 1'b0;
      test_reset();
      test_basic();
      test_irq();
      test_collision();
      test_lock();
      test_unimpl();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/i2c_regbank_arbiter.md
Name: i2c_regbank_arbiter

Overview:
Register bank shared between the I2C slave's register port and a local host port. The I2C side reads combinationally and writes with absolute priority, so it never stalls. Host accesses use a request/ack handshake and are deferred on collision or while an I2C transaction is locked in. A sticky interrupt tells the host that an I2C master wrote to the bank.

Parameters:
ADDR_WIDTH, 8, register address width; matches the slave's REG_ADDR_WIDTH.
DATA_WIDTH, 16, register data width; matches the slave's REG_DATA_WIDTH.
NUM_REGS, 16, number of implemented registers (1..2^ADDR_WIDTH); higher addresses are unimplemented.
LOCK_ON_BUSY, 1, when 1, host accesses wait while i2c_busy is high.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
i2c_write_en  in  1  single-cycle write strobe from the I2C slave
i2c_reg_addr  in  ADDR_WIDTH  I2C register address
i2c_wdata  in  DATA_WIDTH  write data from the I2C slave
i2c_rdata  out  DATA_WIDTH  read data to the I2C slave (combinational)
i2c_busy  in  1  I2C transaction in progress
i2c_done  in  1  I2C transaction finished (level)
host_req  in  1  host request; held high until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_WIDTH  host address
host_wdata  in  DATA_WIDTH  host write data
host_rdata  out  DATA_WIDTH  host read data, valid while host_ack is high
host_ack  out  1  one-cycle completion pulse
host_err  out  1  unimplemented address; valid with host_ack
irq  out  1  sticky flag: an I2C write completed
irq_addr  out  ADDR_WIDTH  last address written over I2C
irq_clr  in  1  clears irq

Behaviour:
- Reset values (reset low, async): all registers 0, host_rdata 0, host_ack 0, host_err 0, irq 0, irq_addr 0, FSM in S_IDLE, wr_seen 0.
- i2c_rdata = regs[i2c_reg_addr] when i2c_reg_addr < NUM_REGS, else 0.
  - It is purely combinational and reflects register contents as of the last clock edge.
- I2C write:
  - On a clock edge with i2c_write_en=1 and an implemented address, regs[addr] <= i2c_wdata; irq_addr <= addr; wr_seen <= 1.
  - Writes to unimplemented addresses are ignored and do not set wr_seen.
- Host FSM states: S_IDLE, S_EXEC, S_ACK.
  - S_IDLE: if host_req=1, capture host_we, host_addr and host_wdata into internal registers, then go to S_EXEC.
  - S_EXEC, stall condition: (LOCK_ON_BUSY && i2c_busy) or i2c_write_en=1. While stalled, stay in S_EXEC.
  - S_EXEC, no stall, unimplemented address: host_err=1; no write; host_rdata=0.
  - S_EXEC, no stall, write: regs[addr] <= captured wdata.
  - S_EXEC, no stall, read: host_rdata <= regs[addr].
  - S_EXEC, on completion: host_ack=1 for this one cycle, then go to S_ACK.
  - S_ACK: host_ack=0, host_err=0. Return to S_IDLE only once host_req=0, which prevents a duplicate accept.
- Latency: host_req sampled high at edge N (S_IDLE→S_EXEC); with no stall, host_ack is high after edge N+1. Each stall cycle adds one cycle.
- Collision: I2C always wins. A deferred host write executes afterwards, so it overwrites the I2C value when both target the same address.
- Lock hold time: an I2C lock can hold the host indefinitely. A host that needs a bound must supply its own timeout.
- irq:
  - On an edge with i2c_done=1 and wr_seen=1: irq <= 1, wr_seen <= 0.
  - irq_clr=1 clears irq; if set and clear occur on the same edge, set wins.
  - An I2C read-only transaction never sets irq.
- Reset mid-access: the pending host request is dropped and no ack is issued. The host must re-request after reset is released.

Test Plan:
- Reset, then host write addr 3 = 0xBEEF followed by read addr 3 → host_ack 2 cycles after req, host_rdata=0xBEEF, host_err=0; i2c_rdata with i2c_reg_addr=3 shows 0xBEEF.
- I2C write addr 5 = 0x1234, then i2c_done high → irq=1 and irq_addr=5 next cycle; irq_clr pulse → irq=0; a later i2c_done with no new write leaves irq=0.
- Host write addr 7 = 0xAAAA issued in the same cycle i2c_write_en writes addr 7 = 0x5555 → host_ack delayed one cycle; final regs[7]=0xAAAA.
- LOCK_ON_BUSY=1, i2c_busy held high 20 cycles during a host read → no ack while busy; ack 1 cycle after busy falls.
- Host read addr 20 with NUM_REGS=16 → host_ack with host_err=1, host_rdata=0; an I2C write to addr 20 leaves irq_addr unchanged.
- Assert reset while the FSM is in S_EXEC → host_ack stays 0, all registers read 0 after release; a new request completes normally.
